// File: rtl/clock_set_controller.sv
// Mode/set sequencer between the two user keys and the clock counter chain.
// Optional hold-to-repeat on the inc key is built when AUTO_REPEAT_EN is defined.

module clock_set_controller_key #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      // Any agreement restarts the run of differing samples.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

module clock_set_controller #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned REP_DELAY     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);

  logic   mode_lvl, inc_lvl;
  logic   mode_lvl_d, inc_lvl_d;
  logic   mode_press, inc_press;
  state_t state_q, state_n;
  logic [7:0] tcnt_q, tcnt_n;
  logic   blink_n, inc_hour_n, inc_min_n, clr_sec_n;
  logic   rep, inc_evt;

`ifdef AUTO_REPEAT_EN
  localparam logic [7:0] HOLD_LAST = 8'(REP_DELAY - 1);
  localparam logic [7:0] HOLD_MAX  = 8'(REP_DELAY);
  logic [7:0] hold_q, hold_n;
`endif

  clock_set_controller_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_mode),
    .level   (mode_lvl)
  );

  clock_set_controller_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_inc (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_inc),
    .level   (inc_lvl)
  );

  // Press events are registered falling edges of the debounced levels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_lvl_d <= 1'b1;
      inc_lvl_d  <= 1'b1;
      mode_press <= 1'b0;
      inc_press  <= 1'b0;
    end else begin
      mode_lvl_d <= mode_lvl;
      inc_lvl_d  <= inc_lvl;
      mode_press <= mode_lvl_d & ~mode_lvl;
      inc_press  <= inc_lvl_d & ~inc_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RUN;
      tcnt_q   <= '0;
      blink    <= 1'b1;
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      clr_sec  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      tcnt_q   <= tcnt_n;
      blink    <= blink_n;
      inc_hour <= inc_hour_n;
      inc_min  <= inc_min_n;
      clr_sec  <= clr_sec_n;
`ifdef AUTO_REPEAT_EN
      hold_q   <= hold_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_q;
    tcnt_n     = tcnt_q;
    blink_n    = blink;
    inc_hour_n = 1'b0;
    inc_min_n  = 1'b0;
    clr_sec_n  = 1'b0;
    rep        = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep = (state_q != RUN) && tick_1hz && !inc_lvl && (hold_q >= HOLD_LAST);
`endif
    inc_evt = inc_press | rep;

    case (state_q)
      RUN: begin
        tcnt_n  = '0;
        blink_n = 1'b1;
        if (mode_press) state_n = SET_HOUR;
      end
      SET_HOUR, SET_MIN: begin
        if (mode_press) begin
          state_n   = (state_q == SET_HOUR) ? SET_MIN : RUN;
          clr_sec_n = (state_q == SET_MIN);
          tcnt_n    = '0;
          blink_n   = 1'b1;
        end else begin
          // An increment on the terminal tick cancels the timeout.
          if (inc_evt) begin
            inc_hour_n = (state_q == SET_HOUR);
            inc_min_n  = (state_q == SET_MIN);
            tcnt_n     = '0;
          end else if (tick_1hz) begin
            if (tcnt_q == TO_LAST) begin
              state_n   = RUN;
              clr_sec_n = 1'b1;
              tcnt_n    = '0;
            end else begin
              tcnt_n = tcnt_q + 8'd1;
            end
          end
          if (tick_1hz) blink_n = (state_n == RUN) ? 1'b1 : ~blink;
        end
      end
      default: begin
        state_n = RUN;
        tcnt_n  = '0;
        blink_n = 1'b1;
      end
    endcase

`ifdef AUTO_REPEAT_EN
    hold_n = hold_q;
    if (state_q == RUN || state_n == RUN || inc_lvl || mode_press) begin
      hold_n = '0;
    end else if (tick_1hz && hold_q < HOLD_MAX) begin
      hold_n = hold_q + 8'd1;
    end
`endif
  end

  assign mode   = state_q;
  assign run_en = (state_q == RUN);

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed table, multi-cycle sequences and
// random key activity checked every cycle against a behavioural model.

module tb_clock_set_controller;

  localparam int DEB    = 4;
  localparam int TMO    = 10;
  localparam int REP    = 3;
  localparam int TICK_P = 10;
`ifdef AUTO_REPEAT_EN
  localparam int EXP_AR = 5;
`else
  localparam int EXP_AR = 1;
`endif

  logic       clk, reset, tick_1hz, key_mode, key_inc;
  logic       run_en, inc_hour, inc_min, clr_sec, blink;
  logic [1:0] mode;

  clock_set_controller #(
    .DEB_CYCLES    (DEB),
    .TIMEOUT_TICKS (TMO),
    .REP_DELAY     (REP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .run_en   (run_en),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .clr_sec  (clr_sec),
    .mode     (mode),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err, cyc;
  int c_ih, c_im, c_clr;

  // Reference model state: mode as 0/1/2, key paths as sample histories.
  int m_mode, m_tcnt, m_hcnt;
  bit m_ih, m_im, m_clr, m_blink;
  bit m_s1[2], m_s2[2], m_deb[2], m_debp[2], m_press[2];
  bit m_hist[2][DEB];
  int m_hv[2];

  function automatic void model_edge(input bit rst_n, input bit tick, input bit raw_m, input bit raw_i);
    bit p_m, p_i, lvl_i, rep, to, used, all_diff;
    bit raw[2];
    if (!rst_n) begin
      m_mode = 0; m_tcnt = 0; m_hcnt = 0;
      m_ih = 0; m_im = 0; m_clr = 0; m_blink = 1;
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1; m_debp[k] = 1; m_press[k] = 0; m_hv[k] = 0;
      end
      return;
    end
    p_m = m_press[0]; p_i = m_press[1]; lvl_i = m_deb[1];
    m_ih = 0; m_im = 0; m_clr = 0; to = 0; rep = 0;
`ifdef AUTO_REPEAT_EN
    rep = (m_mode != 0) && tick && !lvl_i && (m_hcnt >= REP - 1);
`endif
    if (m_mode == 0) begin
      m_tcnt = 0; m_hcnt = 0; m_blink = 1;
      if (p_m) m_mode = 1;
    end else if (p_m) begin
      m_mode = (m_mode + 1) % 3;
      m_clr = (m_mode == 0);
      m_tcnt = 0; m_hcnt = 0; m_blink = 1;
    end else begin
      if (p_i || rep) begin
        if (m_mode == 1) m_ih = 1; else m_im = 1;
        m_tcnt = 0;
      end else if (tick) begin
        m_tcnt++;
        if (m_tcnt >= TMO) begin
          to = 1; m_mode = 0; m_clr = 1; m_tcnt = 0;
        end
      end
      if (tick) m_blink = to ? 1'b1 : !m_blink;
      if (lvl_i || to) m_hcnt = 0;
      else if (tick && m_hcnt < REP) m_hcnt++;
    end
    raw[0] = raw_m; raw[1] = raw_i;
    for (int k = 0; k < 2; k++) begin
      used = m_s2[k]; m_s2[k] = m_s1[k]; m_s1[k] = raw[k];
      for (int j = DEB - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = used;
      if (m_hv[k] < DEB) m_hv[k]++;
      all_diff = (m_hv[k] == DEB);
      for (int j = 0; j < DEB; j++) if (m_hist[k][j] == m_deb[k]) all_diff = 0;
      m_press[k] = m_debp[k] && !m_deb[k];
      m_debp[k] = m_deb[k];
      if (all_diff) m_deb[k] = !m_deb[k];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [6:0] act, exp;
    act = {mode, run_en, inc_hour, inc_min, clr_sec, blink};
    exp = {2'(m_mode), (m_mode == 0), m_ih, m_im, m_clr, m_blink};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL cycle%0d {mode,run_en,inc_hour,inc_min,clr_sec,blink}: got %b expected %b",
                 cyc, act, exp);
    end
  endtask

  // One clock: drive tick, let the edge happen, update model, compare at negedge.
  task automatic cycle();
    tick_1hz = (cyc % TICK_P == TICK_P - 1);
    @(posedge clk);
    model_edge(reset, tick_1hz, key_mode, key_inc);
    @(negedge clk);
    check_cycle();
    c_ih  += int'(inc_hour);
    c_im  += int'(inc_min);
    c_clr += int'(clr_sec);
    cyc++;
  endtask

  task automatic press_keys(input bit km, input bit ki, input int hold);
    key_mode = km; key_inc = ki;
    repeat (hold) cycle();
    key_mode = 1'b1; key_inc = 1'b1;
    repeat (16) cycle();
  endtask

  typedef struct {
    bit km;
    bit ki;
    int hold;
    int exp_mode;
    int exp_ih;
    int exp_im;
    int exp_clr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    bit done;
    n_vec = 0; n_err = 0; cyc = 0;
    c_ih = 0; c_im = 0; c_clr = 0;
    reset = 1'b0; key_mode = 1'b1; key_inc = 1'b1; tick_1hz = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 8, 1, 0, 0, 0};  // mode: RUN -> SET_HOUR
    tbl[1] = '{1'b1, 1'b0, 3, 1, 0, 0, 0};  // glitch on inc, ignored
    tbl[2] = '{1'b1, 1'b0, 8, 1, 1, 0, 0};  // inc in SET_HOUR
    tbl[3] = '{1'b0, 1'b1, 8, 2, 0, 0, 0};  // -> SET_MIN
    tbl[4] = '{1'b1, 1'b0, 8, 2, 0, 1, 0};  // inc in SET_MIN
    tbl[5] = '{1'b0, 1'b1, 8, 0, 0, 0, 1};  // -> RUN with clr_sec
    tbl[6] = '{1'b1, 1'b0, 8, 0, 0, 0, 0};  // inc in RUN ignored
    tbl[7] = '{1'b0, 1'b1, 8, 1, 0, 0, 0};  // -> SET_HOUR
    tbl[8] = '{1'b0, 1'b0, 8, 2, 0, 0, 0};  // both keys: mode wins
    tbl[9] = '{1'b0, 1'b1, 8, 0, 0, 0, 1};  // -> RUN

    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b1;
    chk("reset_mode", mode, 0);
    chk("reset_run_en", run_en, 1);
    chk("reset_blink", blink, 1);
    chk("reset_strobes", {inc_hour, inc_min, clr_sec}, 0);

    for (int i = 0; i < 10; i++) begin
      c_ih = 0; c_im = 0; c_clr = 0;
      press_keys(tbl[i].km, tbl[i].ki, tbl[i].hold);
      chk($sformatf("vec%0d_mode", i), mode, tbl[i].exp_mode);
      chk($sformatf("vec%0d_run_en", i), run_en, (tbl[i].exp_mode == 0));
      chk($sformatf("vec%0d_inc_hour", i), c_ih, tbl[i].exp_ih);
      chk($sformatf("vec%0d_inc_min", i), c_im, tbl[i].exp_im);
      chk($sformatf("vec%0d_clr_sec", i), c_clr, tbl[i].exp_clr);
    end

    // Timeout from SET_MIN with no key activity.
    press_keys(1'b0, 1'b1, 8);
    press_keys(1'b0, 1'b1, 8);
    chk("timeout_in_set_min", mode, 2);
    c_clr = 0; done = 0;
    for (int i = 0; i < 150 && !done; i++) begin
      cycle();
      if (mode == 2'd0) done = 1;
    end
    chk("timeout_returned", done, 1);
    repeat (3) cycle();
    chk("timeout_clr_count", c_clr, 1);

    // Long inc hold in SET_MIN spanning six ticks.
    press_keys(1'b0, 1'b1, 8);
    press_keys(1'b0, 1'b1, 8);
    chk("hold_in_set_min", mode, 2);
    c_ih = 0; c_im = 0;
    key_inc = 1'b0;
    repeat (60) cycle();
    key_inc = 1'b1;
    repeat (16) cycle();
    chk("hold_inc_min_count", c_im, EXP_AR);
    chk("hold_inc_hour_count", c_ih, 0);
    press_keys(1'b0, 1'b1, 8);
    chk("hold_back_to_run", mode, 0);

    // Random key activity, occasional resets and long idle gaps.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
      end
      r = $urandom_range(0, 3);
      key_mode = !(r == 1 || r == 3);
      key_inc  = !(r == 2 || r == 3);
      repeat ($urandom_range(1, 30)) cycle();
      key_mode = 1'b1; key_inc = 1'b1;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(60, 130)) cycle();
      else repeat ($urandom_range(1, 25)) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
